// File: rtl/fwht_sched.sv
// fwht_sched: address and control scheduler for an in-place fast
// Walsh-Hadamard transform over 2**LOG_PTS points. It issues one butterfly
// pair per cycle to a shared, registered add/sub butterfly, and writes each
// result back one cycle later. A one-cycle bubble after every stage lets the
// stage's last write-back land before the next stage reads.
// Optional feature: define FWHT_ABORT_EN to add an "abort" input that
// cancels a running transform.
module fwht_sched #(
  parameter int N       = 4,
  parameter int LOG_PTS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef FWHT_ABORT_EN
  input  logic               abort,
`endif
  output logic               busy,
  output logic               done,
  output logic               rd_en,
  output logic [LOG_PTS-1:0] rd_addr_a,
  output logic [LOG_PTS-1:0] rd_addr_b,
  output logic               wr_en,
  output logic [LOG_PTS-1:0] wr_addr_a,
  output logic [LOG_PTS-1:0] wr_addr_b
);

  // N sizes the datapath outside this block; both parameters must be positive
  if (N < 1 || LOG_PTS < 1) begin : g_bad_param
    $error("fwht_sched: N and LOG_PTS must both be >= 1");
  end

  localparam int PAIRS = 2 ** (LOG_PTS - 1);
  localparam int SW    = (LOG_PTS > 1) ? $clog2(LOG_PTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [SW-1:0]      stage;
  logic [LOG_PTS-1:0] pair;
  logic               last_pair;
  logic               last_stage;
  logic               kill;
  logic [LOG_PTS-1:0] unit;
  logic [LOG_PTS-1:0] low_mask;
  logic [LOG_PTS-1:0] base_addr;

  assign last_pair  = (pair == LOG_PTS'(PAIRS - 1));
  assign last_stage = (stage == SW'(LOG_PTS - 1));

`ifdef FWHT_ABORT_EN
  // Abort only has an effect while a transform is in progress
  assign kill = abort && ((state == S_RUN) || (state == S_DRAIN));
`else
  assign kill = 1'b0;
`endif

  // Control FSM with stage and pair counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      stage <= '0;
      pair  <= '0;
    end else if (kill) begin
      state <= S_IDLE;
      stage <= '0;
      pair  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            stage <= '0;
            pair  <= '0;
          end
        end
        S_RUN: begin
          if (last_pair) state <= S_DRAIN;
          else           pair  <= pair + 1'b1;
        end
        S_DRAIN: begin
          if (last_stage) begin
            state <= S_DONE;
          end else begin
            state <= S_RUN;
            stage <= stage + 1'b1;
            pair  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand a is the pair index with a zero bit spliced in at the stage bit;
  // operand b is the same address with that bit set
  always_comb begin
    unit      = LOG_PTS'(1);
    low_mask  = (unit << stage) - unit;
    base_addr = ((pair & ~low_mask) << 1) | (pair & low_mask);
    rd_addr_a = '0;
    rd_addr_b = '0;
    if (state == S_RUN) begin
      rd_addr_a = base_addr;
      rd_addr_b = base_addr | (unit << stage);
    end
  end

  assign rd_en = (state == S_RUN);
  assign busy  = (state == S_RUN) || (state == S_DRAIN);
  assign done  = (state == S_DONE);

  // Write-back trails the read by the butterfly's one-cycle latency; addresses hold between writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
    end else begin
      wr_en <= rd_en && !kill;
      if (rd_en && !kill) begin
        wr_addr_a <= rd_addr_a;
        wr_addr_b <= rd_addr_b;
      end
    end
  end

endmodule

// File: tb/tb_fwht_sched.sv
// tb_fwht_sched: self-checking bench for fwht_sched with LOG_PTS=3.
// Models an 8x16-bit sample memory and a registered add/sub butterfly
// driven by the scheduler, and checks the cycle-by-cycle address trace and
// the transformed memory against a plain FWHT reference.
module tb_fwht_sched;

  localparam int LP  = 3;
  localparam int NPT = 8;

  typedef logic [15:0] vec_t [NPT];
  typedef struct {
    string name;
    vec_t  din;
    vec_t  dout;
  } vec_rec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
`ifdef FWHT_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy, done, rd_en, wr_en;
  logic [LP-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;

  vec_t          mem;
  vec_t          load_vec;
  logic          load_en = 1'b0;
  logic [15:0]   bf_y1, bf_y2;

  int checks = 0;
  int errors = 0;

  // expected per-cycle trace for one full run, indexed by cycle 0..20
  logic          exp_rd [21];
  logic [LP-1:0] exp_a  [21];
  logic [LP-1:0] exp_b  [21];
  logic          exp_wr [21];
  logic [LP-1:0] exp_wa [21];
  logic [LP-1:0] exp_wb [21];
  logic          exp_busy [21];
  logic          exp_done [21];

  vec_rec_t tbl [5];

  fwht_sched #(.N(4), .LOG_PTS(LP)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FWHT_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;

  // sample memory plus registered butterfly
  always @(posedge clk) begin
    if (load_en) begin
      mem <= load_vec;
    end else if (wr_en) begin
      mem[wr_addr_a] <= bf_y1;
      mem[wr_addr_b] <= bf_y2;
    end
    if (rd_en) begin
      bf_y1 <= mem[rd_addr_a] + mem[rd_addr_b];
      bf_y2 <= mem[rd_addr_a] - mem[rd_addr_b];
    end
  end

  // reference transform: classic butterfly loops over block sizes
  function automatic vec_t fwht_ref(vec_t x);
    vec_t        r;
    logic [15:0] a, b;
    r = x;
    for (int h = 1; h < NPT; h = h * 2)
      for (int i = 0; i < NPT; i = i + 2 * h)
        for (int j = i; j < i + h; j++) begin
          a = r[j];
          b = r[j + h];
          r[j]     = a + b;
          r[j + h] = a - b;
        end
    return r;
  endfunction

  // expected trace: every index with the stage bit clear, in ascending order
  task automatic build_trace();
    int pa [$];
    int pb [$];
    int st, sl;
    for (int s = 0; s < LP; s++)
      for (int j = 0; j < NPT; j++)
        if (((j >> s) & 1) == 0) begin
          pa.push_back(j);
          pb.push_back(j + (1 << s));
        end
    for (int c = 0; c < 21; c++) begin
      exp_rd[c] = 1'b0; exp_a[c] = '0; exp_b[c] = '0;
      exp_busy[c] = (c >= 1 && c <= 15);
      exp_done[c] = (c == 16);
      if (c >= 1 && c <= 15) begin
        st = (c - 1) / 5;
        sl = (c - 1) % 5;
        if (sl < 4) begin
          exp_rd[c] = 1'b1;
          exp_a[c]  = LP'(pa[st * 4 + sl]);
          exp_b[c]  = LP'(pb[st * 4 + sl]);
        end
      end
    end
    exp_wr[0] = 1'b0; exp_wa[0] = '0; exp_wb[0] = '0;
    for (int c = 1; c < 21; c++) begin
      exp_wr[c] = exp_rd[c-1];
      exp_wa[c] = exp_rd[c-1] ? exp_a[c-1] : exp_wa[c-1];
      exp_wb[c] = exp_rd[c-1] ? exp_b[c-1] : exp_wb[c-1];
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  32'(busy),  0);
    check({tag, " done"},  32'(done),  0);
    check({tag, " rd_en"}, 32'(rd_en), 0);
    check({tag, " wr_en"}, 32'(wr_en), 0);
    check({tag, " rd_a"},  32'(rd_addr_a), 0);
    check({tag, " rd_b"},  32'(rd_addr_b), 0);
  endtask

  task automatic check_output(input int c);
    string t;
    t = $sformatf("cyc%0d", c);
    check({t, " busy"},  32'(busy),  32'(exp_busy[c]));
    check({t, " done"},  32'(done),  32'(exp_done[c]));
    check({t, " rd_en"}, 32'(rd_en), 32'(exp_rd[c]));
    check({t, " wr_en"}, 32'(wr_en), 32'(exp_wr[c]));
    if (exp_rd[c]) begin
      check({t, " rd_a"}, 32'(rd_addr_a), 32'(exp_a[c]));
      check({t, " rd_b"}, 32'(rd_addr_b), 32'(exp_b[c]));
    end
    if (exp_wr[c]) begin
      check({t, " wr_a"}, 32'(wr_addr_a), 32'(exp_wa[c]));
      check({t, " wr_b"}, 32'(wr_addr_b), 32'(exp_wb[c]));
    end
  endtask

  task automatic check_mem(input string tag, input vec_t req);
    for (int i = 0; i < NPT; i++)
      check($sformatf("%s mem[%0d]", tag, i), 32'(mem[i]), 32'(req[i]));
  endtask

  task automatic load_mem(input vec_t v);
    @(negedge clk);
    load_vec = v;
    load_en  = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  // start is sampled at edge 0; returns just after that edge
  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input string tag, input vec_t din, input vec_t dout);
    load_mem(din);
    launch();
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check_output(c);
    end
    check_mem(tag, dout);
    @(negedge clk);
    check({tag, " c17 busy"}, 32'(busy), 0);
    check({tag, " c17 done"}, 32'(done), 0);
    check({tag, " hold wr_a"}, 32'(wr_addr_a), 3);
    check({tag, " hold wr_b"}, 32'(wr_addr_b), 7);
  endtask

  initial begin
    vec_t v;
    int   cyc;
    build_trace();

    tbl[0].name = "impulse";
    tbl[0].din  = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[0].dout = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    tbl[1].name = "dc";
    tbl[1].din  = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
    tbl[1].dout = '{16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].name = "three_one";
    tbl[2].din  = '{16'd3, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].dout = '{16'd4, 16'd2, 16'd4, 16'd2, 16'd4, 16'd2, 16'd4, 16'd2};
    tbl[3].name = "alternate";
    tbl[3].din  = '{16'd1, 16'hffff, 16'd1, 16'hffff, 16'd1, 16'hffff, 16'd1, 16'hffff};
    tbl[3].dout = '{16'd0, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[4].name = "wrap";
    tbl[4].din  = '{16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff, 16'h7fff};
    tbl[4].dout = '{16'hfff8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};

    // reset asserted mid-cycle clears outputs immediately, then idle with start low
    #3 rst = 1'b1;
    #1 check_idle("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("idle%0d", i));
      check($sformatf("idle%0d wr_a", i), 32'(wr_addr_a), 0);
    end

    for (int i = 0; i < 5; i++)
      applyStimulus(tbl[i].name, tbl[i].din, tbl[i].dout);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NPT; i++) v[i] = 16'($urandom);
      applyStimulus($sformatf("rand%0d", r), v, fwht_ref(v));
    end

    // start held high: no relaunch while busy or in DONE; relaunch from IDLE at cycle 17
    load_mem(tbl[0].din);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check_output(c);
    end
    @(negedge clk);
    check("hold c17 busy", 32'(busy), 0);
    check("hold c17 rd_en", 32'(rd_en), 0);
    @(negedge clk);
    check("hold c18 busy", 32'(busy), 1);
    check("hold c18 rd_en", 32'(rd_en), 1);
    check("hold c18 rd_a", 32'(rd_addr_a), 0);
    check("hold c18 rd_b", 32'(rd_addr_b), 1);
    start = 1'b0;
    cyc = 18;
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check("hold second done cycle", 32'(cyc), 33);
    check_mem("twice", '{16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0});

    // reset in cycle 7 returns to idle with no done; a fresh run then completes
    load_mem(tbl[1].din);
    launch();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_output(c);
    end
    #2 rst = 1'b1;
    #1 check_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("postrst%0d", i));
    end
    applyStimulus("after_rst", tbl[2].din, tbl[2].dout);

`ifdef FWHT_ABORT_EN
    // abort in cycle 7 stops reads and write-backs from cycle 8, no done
    load_mem(tbl[1].din);
    launch();
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      check_output(c);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort c8");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle($sformatf("postabort%0d", i));
    end
    applyStimulus("after_abort", tbl[3].din, tbl[3].dout);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
